ena_scheduler: RTL and testbench
================================

# ena_scheduler

Firing scheduler driving the `ena` vector of the synchronous circuit model. Each cycle it takes the set of currently excited signals (input DFFs and gate output DFFs whose next value differs from their current value) and selects which ones fire on the next clock edge, according to a programmable policy. It also counts firings and flags deadlock. It sits directly upstream of the generated `circuit` module: `ena` connects bit-for-bit to the circuit's `ena` port, and the excitation vector is derived from the circuit's D/Q pairs.

## Interface
- `N`, 8: number of enable bits; equals inputs + gates of the target circuit; 2..64
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero
- `DL_CYCLES`, 4: consecutive idle running cycles before deadlock is raised; ≥1
- `CW`, 32: width of `fire_count`

- `clk`  in  1  clock, shared with the circuit model
- `reset`  in  1  synchronous, active-high
- `run`  in  1  free-run enable
- `step`  in  1  single-step request; fires one scheduling decision when `run`=0
- `mode`  in  2  policy: 0 round-robin single, 1 random single, 2 random subset, 3 all excited
- `excited`  in  N  bit i = signal i may fire this cycle
- `ena`  out  N  fire mask to circuit, combinational from current inputs and state
- `fire_count`  out  CW  saturating count of individual signal firings
- `idle`  out  1  `excited`==0, combinational
- `deadlock`  out  1  sticky deadlock flag

## Operation
- Active cycle: `reset`=0 and (`run`=1 or `step`=1). On any other cycle, `ena`=0 and all state holds, except that reset reinitialises it.
- `ena` is always a subset of `excited`. Never fire a non-excited bit; the circuit DFFs toggle inputs unconditionally.
- Internal state:
  - `ptr` (clog2 N bits), round-robin start index
  - `lfsr`, 16-bit Fibonacci, taps 16,14,13,11
  - `dl_cnt`, idle-run counter
  - `fire_count`, `deadlock`
- Mode 0: `ena` = one-hot of the first excited bit at index ≥ `ptr`, wrapping through N-1 to 0. After firing bit k, `ptr` becomes (k+1) mod N.
- Mode 1: the start index s = `lfsr[IW-1:0]`, where IW = clog2(N); if s ≥ N, s = s−N. Then search as in mode 0 from s. `ptr` is unchanged.
- Mode 2: `ena` = `excited` & M, where M is `lfsr` replicated to N bits. If that result is 0 and `excited` ≠ 0, fall back to the mode-1 selection.
- Mode 3: `ena` = `excited`.
- `lfsr` advances once per active cycle, in every mode.
- `fire_count` adds popcount(`ena`) each active cycle and saturates at 2^CW−1.
- Deadlock:
  - On an active cycle with `run`=1 and `excited`=0, `dl_cnt` increments, saturating at DL_CYCLES. Any cycle with `excited`≠0 clears it.
  - `deadlock` sets on the edge where `dl_cnt` reaches DL_CYCLES. It clears only on reset.
  - Step-only cycles do not touch `dl_cnt`.
- `step` is level-sampled: software/bench must pulse it for one cycle per step. `step` is ignored when `run`=1.
- `mode` may change on any cycle; the new policy applies to that cycle's `ena`.

## Timing
- Zero-latency decision: `ena` reflects `excited`, `mode` and the registered `ptr`/`lfsr` in the same cycle. The circuit DFFs capture on the following edge, and the new `excited` is visible the cycle after.
- Reset values, asserted on the first edge with `reset`=1:
  - `ptr`=0, `lfsr`=SEED, `dl_cnt`=0, `fire_count`=0, `deadlock`=0
  - `ena`=0 while `reset`=1, combinationally, so no firing coincides with circuit reset.
- Reset mid-run: the firing is dropped for that cycle and all state is reinitialised. The first active cycle after reset uses `ptr`=0 and `lfsr`=SEED.
- Wrap-around: with `ptr`=N−1 and only bit 0 excited, mode 0 fires bit 0 and `ptr` becomes 1.
- `excited`=0 on an active cycle: `ena`=0, `ptr` holds, `lfsr` still advances.
- Worst-case combinational path: N-bit priority search from a rotating start; it must close at the circuit clock rate.

## Test plan
- Reset then round-robin, N=8: `excited`=8'hFF, `mode`=0, `run`=1 for 10 cycles → `ena` sequence 01,02,04,…,80,01,02; `fire_count`=10.
- Round-robin wrap: set `ptr`=7 by firing bit 6, then `excited`=8'h01 → `ena`=8'h01 and next `ptr`=1; `excited`=8'h81 from `ptr`=7 → `ena`=8'h80.
- Modes 1/2/3 with `excited`=8'h5A over 200 cycles → `ena` ⊆ 8'h5A every cycle; mode 1 is always one-hot; mode 3 gives `ena`=8'h5A; a reset replay with SEED reproduces the identical sequence.
- Deadlock, DL_CYCLES=4: `run`=1, `excited`=0 for 3 cycles, then 8'h04 → `deadlock`=0. Then 4 idle cycles → `deadlock`=1 on the 4th edge, and it stays 1 after `excited` returns nonzero until `reset`.
- Step mode: `run`=0, `excited`=8'hFF, one-cycle `step` pulses at cycles 2 and 7 → `ena` nonzero only in cycles 2 and 7; `fire_count`=2; `deadlock` unaffected by idle steps.
- Reset mid-run: `reset`=1 on a cycle with `excited`=8'hFF, `mode`=3 → `ena`=0 that cycle; next cycle `fire_count`=0, and mode 0 fires bit 0 first.

Source files
------------

// File: rtl/ena_scheduler.sv
// Firing scheduler: picks which excited signals of the circuit model fire on the next edge,
// under a selectable policy, while counting firings and watching for deadlock.
module ena_scheduler #(
  parameter int          N         = 8,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          DL_CYCLES = 4,
  parameter int          CW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          step,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  excited,
  output logic [N-1:0]  ena,
  output logic [CW-1:0] fire_count,
  output logic          idle,
  output logic          deadlock
);

  localparam int IW = $clog2(N);
  localparam int DW = $clog2(DL_CYCLES + 1);
  localparam int PW = $clog2(N + 1);

  logic [IW-1:0]  ptr;
  logic [15:0]    lfsr;
  logic [DW-1:0]  dl_cnt;

  logic           active;
  logic [IW-1:0]  rnd_start;
  logic [IW:0]    rr_hit;
  logic [IW:0]    rnd_hit;
  logic [N-1:0]   mask;
  logic [PW-1:0]  pop;
  logic [CW:0]    fc_sum;
  logic [15:0]    lfsr_next;
  logic [IW-1:0]  ptr_next;

  // Returns {found, index} of the first set bit at or after start, wrapping through N-1 to 0.
  // Walking offsets from high to low lets the smallest offset win without an early exit.
  function automatic logic [IW:0] search(input logic [N-1:0] ex, input logic [IW-1:0] start);
    logic [IW:0]   r;
    logic [IW-1:0] idx;
    r = '0;
    for (int j = N - 1; j >= 0; j--) begin
      idx = IW'((int'(start) + j) % N);
      if (ex[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign idle      = (excited == '0);
  assign active    = !reset && (run || step);
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_comb begin
    rnd_start = lfsr[IW-1:0];
    if ({1'b0, rnd_start} >= (IW+1)'(N)) rnd_start = rnd_start - IW'(N);
    rr_hit  = search(excited, ptr);
    rnd_hit = search(excited, rnd_start);
    for (int i = 0; i < N; i++) mask[i] = lfsr[i % 16];
  end

  always_comb begin
    ena = '0;
    if (active) begin
      case (mode)
        2'd0: if (rr_hit[IW])  ena[rr_hit[IW-1:0]]  = 1'b1;
        2'd1: if (rnd_hit[IW]) ena[rnd_hit[IW-1:0]] = 1'b1;
        2'd2: begin
          ena = excited & mask;
          if (ena == '0 && rnd_hit[IW]) ena[rnd_hit[IW-1:0]] = 1'b1;
        end
        default: ena = excited;
      endcase
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + PW'(ena[i]);
    fc_sum   = {1'b0, fire_count} + (CW+1)'(pop);
    ptr_next = (rr_hit[IW-1:0] == IW'(N - 1)) ? '0 : rr_hit[IW-1:0] + 1'b1;
  end

  // Only run cycles feed the deadlock counter; single steps leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      lfsr       <= SEED;
      dl_cnt     <= '0;
      fire_count <= '0;
      deadlock   <= 1'b0;
    end else if (active) begin
      lfsr       <= lfsr_next;
      fire_count <= fc_sum[CW] ? '1 : fc_sum[CW-1:0];
      if (mode == 2'd0 && rr_hit[IW]) ptr <= ptr_next;
      if (run) begin
        if (excited != '0) begin
          dl_cnt <= '0;
        end else begin
          if (dl_cnt < DW'(DL_CYCLES)) dl_cnt <= dl_cnt + 1'b1;
          if (dl_cnt >= DW'(DL_CYCLES - 1)) deadlock <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ena_scheduler.sv
// Self-checking bench for ena_scheduler: directed scenarios plus random traffic
// compared against an integer-level reference model of the firing policies.
module tb_ena_scheduler;

  localparam int N  = 8;
  localparam int IW = $clog2(N);
  localparam int DL = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [N-1:0]  excited = '0;
  logic [N-1:0]  ena;
  logic [CW-1:0] fire_count;
  logic          idle;
  logic          deadlock;

  int errors = 0;
  int checks = 0;

  int          m_ptr;
  int unsigned m_lfsr;
  int          m_dl;
  longint      m_fc;
  bit          m_dead;
  bit          m_known = 1'b0;

  ena_scheduler #(.N(N), .SEED(16'hACE1), .DL_CYCLES(DL), .CW(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .mode(mode),
    .excited(excited), .ena(ena), .fire_count(fire_count), .idle(idle), .deadlock(deadlock)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int find_from(input int ex, input int start);
    for (int j = 0; j < N; j++) begin
      int idx;
      idx = (start + j) % N;
      if (((ex >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  function automatic int rand_start();
    int s;
    s = int'(m_lfsr % (1 << IW));
    if (s >= N) s -= N;
    return s;
  endfunction

  function automatic int model_ena(input int md, input int ex, input bit act);
    int k, msk, r;
    if (!act) return 0;
    case (md)
      0: begin k = find_from(ex, m_ptr); return (k < 0) ? 0 : (1 << k); end
      1: begin k = find_from(ex, rand_start()); return (k < 0) ? 0 : (1 << k); end
      2: begin
        msk = 0;
        for (int i = 0; i < N; i++) msk |= int'((m_lfsr >> (i % 16)) & 1) << i;
        r = ex & msk;
        if (r == 0 && ex != 0) begin
          k = find_from(ex, rand_start());
          r = 1 << k;
        end
        return r;
      end
      default: return ex;
    endcase
  endfunction

  // Drives one cycle, compares all outputs with the model, then advances the model past the edge.
  task automatic applyStimulus(input bit r, input bit ru, input bit st, input int md, input int ex);
    bit act;
    int exp, k;
    int unsigned fb;
    @(negedge clk);
    reset = r; run = ru; step = st; mode = md[1:0]; excited = ex[N-1:0];
    #1;
    act = !r && (ru || st);
    exp = model_ena(md, ex, act);
    checkOutput("ena", 64'(ena), 64'(exp));
    checkOutput("idle", 64'(idle), 64'(ex == 0));
    if (m_known) begin
      checkOutput("fire_count", 64'(fire_count), 64'(m_fc));
      checkOutput("deadlock", 64'(deadlock), 64'(m_dead));
    end
    if (r) begin
      m_ptr = 0; m_lfsr = 32'hACE1; m_dl = 0; m_fc = 0; m_dead = 0; m_known = 1'b1;
    end else if (act) begin
      m_fc += $countones(exp);
      if (m_fc > 64'hFFFF_FFFF) m_fc = 64'hFFFF_FFFF;
      if (md == 0) begin
        k = find_from(ex, m_ptr);
        if (k >= 0) m_ptr = (k + 1) % N;
      end
      fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
      m_lfsr = ((m_lfsr << 1) | fb) & 32'hFFFF;
      if (ru) begin
        if (ex == 0) begin
          if (m_dl < DL) m_dl++;
          if (m_dl == DL) m_dead = 1;
        end else begin
          m_dl = 0;
        end
      end
    end
  endtask

  initial begin
    logic [N-1:0] rec[200];
    int modes[200];

    // Reset state and round-robin over all-excited.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("reset_fc", 64'(fire_count), 64'd0);
    checkOutput("reset_dead", 64'(deadlock), 64'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 0, 0, 8'hFF);
      checkOutput("rr_seq", 64'(ena), 64'(1 << (i % 8)));
    end
    applyStimulus(0, 0, 0, 0, 8'hFF);
    checkOutput("rr_fc", 64'(fire_count), 64'd10);

    // Round-robin wrap-around.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 8'h40);
    checkOutput("wrap_b6", 64'(ena), 64'h40);
    applyStimulus(0, 1, 0, 0, 8'h01);
    checkOutput("wrap_b0", 64'(ena), 64'h01);
    applyStimulus(0, 1, 0, 0, 8'h40);
    applyStimulus(0, 1, 0, 0, 8'h81);
    checkOutput("wrap_b7", 64'(ena), 64'h80);

    // Random policies on a fixed excitation, then a seeded replay.
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      modes[i] = int'($urandom_range(1, 3));
      applyStimulus(0, 1, 0, modes[i], 8'h5A);
      rec[i] = ena;
      checkOutput("subset", 64'(ena & ~8'h5A), 64'd0);
      if (modes[i] == 1) checkOutput("m1_onehot", 64'($onehot(ena)), 64'd1);
      if (modes[i] == 3) checkOutput("m3_all", 64'(ena), 64'h5A);
    end
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0, 1, 0, modes[i], 8'h5A);
      checkOutput("replay", 64'(ena), 64'(rec[i]));
    end

    // Deadlock detection and stickiness.
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 8'h04);
    checkOutput("dl_early", 64'(deadlock), 64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("dl_pending", 64'(deadlock), 64'd0);
    end
    applyStimulus(0, 1, 0, 0, 8'hFF);
    checkOutput("dl_set", 64'(deadlock), 64'd1);
    applyStimulus(0, 1, 0, 0, 8'hFF);
    checkOutput("dl_sticky", 64'(deadlock), 64'd1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("dl_clear", 64'(deadlock), 64'd0);

    // Single-step behaviour.
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 0, (c == 2 || c == 7), 0, 8'hFF);
      checkOutput("step_ena", 64'(ena != 0), 64'(c == 2 || c == 7));
    end
    applyStimulus(0, 0, 0, 0, 8'hFF);
    checkOutput("step_fc", 64'(fire_count), 64'd2);
    for (int c = 0; c < 6; c++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("step_nodl", 64'(deadlock), 64'd0);

    // Reset mid-run.
    for (int c = 0; c < 3; c++) applyStimulus(0, 1, 0, 3, 8'hFF);
    applyStimulus(1, 1, 0, 3, 8'hFF);
    checkOutput("mid_reset_ena", 64'(ena), 64'd0);
    applyStimulus(0, 1, 0, 0, 8'hFF);
    checkOutput("mid_reset_fc", 64'(fire_count), 64'd0);
    checkOutput("mid_reset_first", 64'(ena), 64'h01);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int ex;
      ex = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
      applyStimulus($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), ex);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
